// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// alu_pkg: shared types and constants for the ALU subsystem sequencer.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

   localparam int OPCODE_W = 4;
   localparam int FLAGS_W  = 4;

   // Bit positions inside the packed {OF,SF,ZF,CF} flag vector
   localparam int OF_B = 3;
   localparam int SF_B = 2;
   localparam int ZF_B = 1;
   localparam int CF_B = 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      EXEC   = 3'd3,
      READ   = 3'd4,
      RESP   = 3'd5
   } alu_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_sub_ctrl_reg.sv
//------------------------------------------------------------------------------
// alu_sub_ctrl_reg: enabled register with asynchronous clear.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_sub_ctrl_reg #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

`default_nettype wire

// File: rtl/alu_sub_ctrl.sv
//------------------------------------------------------------------------------
// alu_sub_ctrl: sequences one request through the ALU subsystem strobes and
// returns the captured result on a valid/ready response port.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_sub_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int ALU_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [OPCODE_W-1:0] req_op,
   input  logic [WIDTH-1:0]    req_a,
   input  logic [WIDTH-1:0]    req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WIDTH-1:0]    rsp_data,
   output logic [FLAGS_W-1:0]  rsp_flags,
   output logic [WIDTH-1:0]    data,
   output logic                a_en,
   output logic                b_en,
   output logic                alu_en,
   output logic                alu_oe,
   output logic [OPCODE_W-1:0] opcode,
   input  logic [WIDTH-1:0]    alu_data,
   input  logic                of,
   input  logic                sf,
   input  logic                zf,
   input  logic                cf
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam int CAP_W = WIDTH + FLAGS_W;

   alu_seq_state_t      state;
   logic [OPCODE_W-1:0] op_lat;
   logic [WIDTH-1:0]    a_lat;
   logic [WIDTH-1:0]    b_lat;
   logic [CNT_W-1:0]    exec_cnt;
   logic [FLAGS_W-1:0]  flags_in;
   logic [CAP_W-1:0]    cap_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_lat   <= '0;
         a_lat    <= '0;
         b_lat    <= '0;
         exec_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_lat <= req_op;
                  a_lat  <= req_a;
                  b_lat  <= req_b;
                  state  <= LOAD_A;
               end
            end
            LOAD_A: state <= LOAD_B;
            LOAD_B: begin
               exec_cnt <= CNT_W'(ALU_LAT - 1);
               state    <= EXEC;
            end
            EXEC: begin
               if (exec_cnt == '0)
                  state <= READ;
               else
                  exec_cnt <= exec_cnt - 1'b1;
            end
            READ: state <= RESP;
            RESP: begin
               if (rsp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes decode from state only, so request inputs never reach them combinationally
   always_comb begin
      req_ready = (state == IDLE) && !rst;
      rsp_valid = (state == RESP);
      a_en      = (state == LOAD_A);
      b_en      = (state == LOAD_B);
      alu_en    = (state == EXEC);
      alu_oe    = (state == READ);
      data      = '0;
      if (state == LOAD_A)
         data = a_lat;
      else if (state == LOAD_B)
         data = b_lat;
      opcode = '0;
      if ((state == LOAD_A) || (state == LOAD_B) || (state == EXEC) || (state == READ))
         opcode = op_lat;
   end

   always_comb begin
      flags_in       = '0;
      flags_in[OF_B] = of;
      flags_in[SF_B] = sf;
      flags_in[ZF_B] = zf;
      flags_in[CF_B] = cf;
   end

   alu_sub_ctrl_reg #(
      .WIDTH (CAP_W)
   ) u_cap (
      .clk (clk),
      .rst (rst),
      .en  (state == READ),
      .d   ({alu_data, flags_in}),
      .q   (cap_q)
   );

   assign rsp_data  = cap_q[CAP_W-1:FLAGS_W];
   assign rsp_flags = cap_q[FLAGS_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_alu_sub_ctrl.sv
//------------------------------------------------------------------------------
// tb_alu_sub_ctrl: directed self-checking bench with a small ALU stub.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         checks = 0;
   int         errors = 0;

   // DUT with ALU_LAT=1
   logic       req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1;
   logic [3:0] req_op = '0, rsp_flags, opcode;
   logic [7:0] req_a = '0, req_b = '0, rsp_data, data, alu_data;
   logic       a_en, b_en, alu_en, alu_oe, of, sf, zf, cf;

   // DUT with ALU_LAT=3
   logic       d3_req_valid = 1'b0, d3_req_ready, d3_rsp_valid, d3_rsp_ready = 1'b1;
   logic [3:0] d3_req_op = 4'h2, d3_rsp_flags, d3_opcode;
   logic [7:0] d3_req_a = 8'h12, d3_req_b = 8'h34, d3_rsp_data, d3_data, d3_alu_data;
   logic       d3_a_en, d3_b_en, d3_alu_en, d3_alu_oe;

   always #5 clk = ~clk;

   alu_sub_ctrl #(.WIDTH(8), .ALU_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags),
      .data(data), .a_en(a_en), .b_en(b_en), .alu_en(alu_en), .alu_oe(alu_oe),
      .opcode(opcode), .alu_data(alu_data),
      .of(of), .sf(sf), .zf(zf), .cf(cf)
   );

   alu_sub_ctrl #(.WIDTH(8), .ALU_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_op(d3_req_op),
      .req_a(d3_req_a), .req_b(d3_req_b),
      .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
      .rsp_data(d3_rsp_data), .rsp_flags(d3_rsp_flags),
      .data(d3_data), .a_en(d3_a_en), .b_en(d3_b_en), .alu_en(d3_alu_en), .alu_oe(d3_alu_oe),
      .opcode(d3_opcode), .alu_data(d3_alu_data),
      .of(d3_alu_oe), .sf(1'b0), .zf(d3_alu_oe), .cf(1'b0)
   );

   assign d3_alu_data = d3_alu_oe ? 8'hA5 : 8'h00;

   // ALU stub: op 0 = A+B, op 1 = A-B, op 2 = A&B; result packed as {res, OF, SF, ZF, CF}
   logic [7:0]  alu_ra = '0, alu_rb = '0;
   logic [11:0] alu_res = '0;

   function automatic logic [11:0] alu_calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] w;
      logic       ovf;
      case (op)
         4'h0: begin w = {1'b0, a} + {1'b0, b}; ovf = (a[7] == b[7]) && (w[7] != a[7]); end
         4'h1: begin w = {1'b0, a} - {1'b0, b}; ovf = (a[7] != b[7]) && (w[7] != a[7]); end
         default: begin w = {1'b0, a & b}; ovf = 1'b0; end
      endcase
      return {w[7:0], ovf, w[7], (w[7:0] == 8'h00), w[8]};
   endfunction

   always @(posedge clk) begin
      if (a_en)   alu_ra  <= data;
      if (b_en)   alu_rb  <= data;
      if (alu_en) alu_res <= alu_calc(opcode, alu_ra, alu_rb);
   end

   assign alu_data       = alu_oe ? alu_res[11:4] : 8'h00;
   assign {of, sf, zf, cf} = alu_oe ? alu_res[3:0] : 4'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("onehot", 32'($countones({a_en, b_en, alu_en, alu_oe}) <= 1), 1);
         check("onehot3", 32'($countones({d3_a_en, d3_b_en, d3_alu_en, d3_alu_oe}) <= 1), 1);
      end
   end

   task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input logic [3:0] exp_f);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      check({tag, "_ready"}, req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      // Operand changes after acceptance must not leak onto the bus
      req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = ~op;
      check({tag, "_a_en"}, a_en, 1);
      check({tag, "_data_a"}, data, a);
      check({tag, "_opcode"}, opcode, op);
      @(negedge clk);
      check({tag, "_b_en"}, b_en, 1);
      check({tag, "_data_b"}, data, b);
      n = 1;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      check({tag, "_latency"}, n, 4);
      check({tag, "_rsp_data"}, rsp_data, exp_d);
      check({tag, "_rsp_flags"}, rsp_flags, exp_f);
      check({tag, "_data_idle"}, data, 0);
      @(posedge clk);
   endtask

   initial begin
      int n, en_cnt, first, last;

      // Reset state
      @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_strobes", {a_en, b_en, alu_en, alu_oe, rsp_valid}, 0);
      check("rst_data", {rsp_data, rsp_flags, data, opcode}, 0);
      rst = 1'b0;
      #1 check("rel_ready", req_ready, 1);

      // Single op and carry/zero
      run_op("add", 4'h0, 8'h05, 8'h03, 8'h08, 4'b0000);
      run_op("carry", 4'h0, 8'hFF, 8'h01, 8'h00, 4'b0011);
      run_op("add2", 4'h0, 8'h05, 8'h03, 8'h08, 4'b0000);

      // Reset asserted while in EXEC
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'h1; req_a = 8'h09; req_b = 8'h02;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_exec_alu_en", alu_en, 1);
      #2 rst = 1'b1;
      #1;
      check("async_strobes", {a_en, b_en, alu_en, alu_oe, rsp_valid}, 0);
      check("async_bus", {data, opcode}, 0);
      check("async_rsp_clr", {rsp_data, rsp_flags}, 0);
      @(negedge clk);
      check("rst_hold_strobes", {a_en, b_en, alu_en, alu_oe, rsp_valid, req_ready}, 0);
      rst = 1'b0;
      #1 check("rel2_ready", req_ready, 1);

      // Back-pressure: 40+40 = 80, OF and SF set
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'h0; req_a = 8'h40; req_b = 8'h40;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      check("bp_valid", rsp_valid, 1);
      req_valid = 1'b1; req_op = 4'h2; req_a = 8'h11; req_b = 8'h22;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_valid", rsp_valid, 1);
         check("bp_hold_data", {rsp_data, rsp_flags}, {8'h80, 4'b1100});
         check("bp_ready_low", req_ready, 0);
         check("bp_no_load", a_en, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_done", rsp_valid, 0);
      check("bp_keep_data", {rsp_data, rsp_flags}, {8'h80, 4'b1100});
      check("bp_idle_ready", req_ready, 1);
      @(negedge clk);
      check("bp_ignored", {a_en, data}, 0);

      // Back-to-back sequence, responses in order
      run_op("b2b0", 4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100);
      run_op("b2b1", 4'h1, 8'h10, 8'h20, 8'hF0, 4'b0101);
      run_op("b2b2", 4'h2, 8'hF0, 8'h3C, 8'h30, 4'b0000);
      run_op("b2b3", 4'h0, 8'h80, 8'h80, 8'h00, 4'b1011);

      // ALU_LAT=3 timing
      @(negedge clk);
      d3_req_valid = 1'b1;
      check("lat3_ready", d3_req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      d3_req_valid = 1'b0;
      n = 0; en_cnt = 0; first = -1; last = -1;
      while (!d3_rsp_valid && n < 50) begin
         if (d3_alu_en) begin
            en_cnt++;
            if (first < 0) first = n;
            last = n;
         end
         @(negedge clk);
         n++;
      end
      check("lat3_latency", n, 6);
      check("lat3_en_cycles", en_cnt, 3);
      check("lat3_en_contig", last - first, 2);
      check("lat3_data", d3_rsp_data, 8'hA5);
      check("lat3_flags", d3_rsp_flags, 4'b1010);
      @(negedge clk);
      check("lat3_done", {d3_rsp_valid, d3_req_ready}, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
